// File: rtl/mhd_err_monitor_if.sv
// -----------------------------------------------------------------------------
// mhd_err_monitor_if
//   Bundles the sample stream, run control and run statistics of the
//   MHD error-rate monitor.
//
//   Optional feature macro: MHD_TRACE_EN (adds the first-violation trace
//   signals below).
//
//   Signals (direction seen from the monitor, i.e. the slave modport):
//     start        in   run start pulse
//     num_samples  in   run length, sampled on start
//     in_valid     in   exact/approx sample present
//     in_ready     out  monitor accepts a sample this cycle
//     exact        in   golden output word
//     approx       in   approximate output word
//     busy         out  run in progress (RUN or DRAIN)
//     done         out  run finished, level until the next start
//     fail         out  done with at least one violating sample
//     err_count    out  number of samples with HD > MHD, saturating
//     max_hd       out  largest Hamming distance seen in the run
//     trace_*      out  first violating sample (MHD_TRACE_EN only)
// -----------------------------------------------------------------------------
interface mhd_err_monitor_if #(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned CNT_W = 16,
   parameter int unsigned HW    = $clog2(WIDTH + 1)
);

   logic             start;
   logic [CNT_W-1:0] num_samples;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] exact;
   logic [WIDTH-1:0] approx;
   logic             busy;
   logic             done;
   logic             fail;
   logic [CNT_W-1:0] err_count;
   logic [HW-1:0]    max_hd;
`ifdef MHD_TRACE_EN
   logic             trace_valid;
   logic [CNT_W-1:0] trace_idx;
   logic [WIDTH-1:0] trace_exact;
   logic [WIDTH-1:0] trace_approx;
`endif

   // Stimulus side (sample source and run controller).
   modport master (
      output start,
      output num_samples,
      output in_valid,
      output exact,
      output approx,
      input  in_ready,
      input  busy,
      input  done,
      input  fail,
      input  err_count,
      input  max_hd
`ifdef MHD_TRACE_EN
      ,
      input  trace_valid,
      input  trace_idx,
      input  trace_exact,
      input  trace_approx
`endif
   );

   // Monitor side.
   modport slave (
      input  start,
      input  num_samples,
      input  in_valid,
      input  exact,
      input  approx,
      output in_ready,
      output busy,
      output done,
      output fail,
      output err_count,
      output max_hd
`ifdef MHD_TRACE_EN
      ,
      output trace_valid,
      output trace_idx,
      output trace_exact,
      output trace_approx
`endif
   );

endinterface

// File: rtl/mhd_err_monitor.sv
// -----------------------------------------------------------------------------
// mhd_err_monitor
//   Streaming error-rate monitor placed behind the exact and approximate
//   circuit outputs. Each accepted sample has its Hamming distance computed,
//   compared against the MHD bound, and folded into run statistics collected
//   over a programmed number of samples.
//
//   Optional feature macro: MHD_TRACE_EN
//     Defined  : the first violating sample of a run (index, exact, approx)
//                is captured on the trace_* signals of the interface.
//     Undefined: no trace signals or registers exist.
//
//   Ports:
//     clk     in   rising-edge clock
//     rst_n   in   asynchronous active-low reset; aborts any run in progress
//     io_mon  --   mhd_err_monitor_if.slave: run control, sample stream and
//                  run statistics (see the interface file for the list)
//
//   Pipeline:
//     S1  register hd = popcount(exact ^ approx) with a valid bit
//     S2  apply S1 to err_count / max_hd (and the trace) on the next edge
//   S2 has no holding register of its own: a sample leaves the pipeline on
//   the edge that applies it, so "pipeline empty" means S1 is empty.
// -----------------------------------------------------------------------------
module mhd_err_monitor #(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned MHD   = 3,
   parameter int unsigned CNT_W = 16
) (
   input logic               clk,
   input logic               rst_n,
   mhd_err_monitor_if.slave  io_mon
);

   localparam int unsigned HW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } state_e;

   // ---------------------------------------------------------------------------
   // Declarations
   // ---------------------------------------------------------------------------
   state_e           r_state;
   state_e           w_state_nxt;

   logic [CNT_W-1:0] r_num;
   logic [CNT_W-1:0] r_acc_cnt;
   logic [CNT_W-1:0] w_acc_inc;

   logic             w_start_ok;
   logic             w_accept;
   logic             w_last_accept;

   logic [WIDTH-1:0] w_diff;
   logic [HW-1:0]    w_hd;

   logic             r_s1_valid;
   logic [HW-1:0]    r_s1_hd;
   logic             w_s1_viol;

   logic [CNT_W-1:0] r_err_count;
   logic [HW-1:0]    r_max_hd;

   // ---------------------------------------------------------------------------
   // Handshake and run bookkeeping
   // ---------------------------------------------------------------------------
   // start only has an effect from IDLE or DONE; in RUN/DRAIN it is ignored.
   assign w_start_ok    = io_mon.start && ((r_state == StIdle) || (r_state == StDone));
   assign w_accept      = io_mon.in_valid && (r_state == StRun);
   assign w_acc_inc     = r_acc_cnt + CNT_W'(1);
   // The counter stops at num_samples, so it can never wrap.
   assign w_last_accept = w_accept && (w_acc_inc == r_num);

   // ---------------------------------------------------------------------------
   // Hamming distance of the incoming sample
   // ---------------------------------------------------------------------------
   assign w_diff = io_mon.exact ^ io_mon.approx;

   always_comb begin
      w_hd = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         w_hd = w_hd + HW'(w_diff[i]);
      end
   end

   // Unsigned compare; hd == MHD is still within bound.
   assign w_s1_viol = (32'(r_s1_hd) > MHD);

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StIdle, StDone: begin
            if (io_mon.start) begin
               // An empty run finishes immediately with clean statistics.
               w_state_nxt = (io_mon.num_samples == '0) ? StDone : StRun;
            end
         end
         StRun: begin
            if (w_last_accept) begin
               w_state_nxt = StDrain;
            end
         end
         StDrain: begin
            if (!r_s1_valid) begin
               w_state_nxt = StDone;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Run length and accept counter
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_num     <= '0;
         r_acc_cnt <= '0;
      end else if (w_start_ok) begin
         r_num     <= io_mon.num_samples;
         r_acc_cnt <= '0;
      end else if (w_accept) begin
         r_acc_cnt <= w_acc_inc;
      end
   end

   // ---------------------------------------------------------------------------
   // S1: registered Hamming distance
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_hd    <= '0;
      end else begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_hd <= w_hd;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // S2: statistics update
   // ---------------------------------------------------------------------------
   // The pipeline is always empty in IDLE/DONE, so a clear on start can never
   // collide with a pending S1 sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_count <= '0;
         r_max_hd    <= '0;
      end else if (w_start_ok) begin
         r_err_count <= '0;
         r_max_hd    <= '0;
      end else if (r_s1_valid) begin
         if (w_s1_viol && (r_err_count != '1)) begin
            r_err_count <= r_err_count + CNT_W'(1);
         end
         if (r_s1_hd > r_max_hd) begin
            r_max_hd <= r_s1_hd;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Optional first-violation trace
   // ---------------------------------------------------------------------------
`ifdef MHD_TRACE_EN
   logic [CNT_W-1:0] r_s1_idx;
   logic [WIDTH-1:0] r_s1_exact;
   logic [WIDTH-1:0] r_s1_approx;

   logic             r_trc_valid;
   logic [CNT_W-1:0] r_trc_idx;
   logic [WIDTH-1:0] r_trc_exact;
   logic [WIDTH-1:0] r_trc_approx;

   // S1 carries the sample words and its 0-based accept index so that the
   // capture can happen alongside the statistics update in S2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_idx    <= '0;
         r_s1_exact  <= '0;
         r_s1_approx <= '0;
      end else if (w_accept) begin
         r_s1_idx    <= r_acc_cnt;
         r_s1_exact  <= io_mon.exact;
         r_s1_approx <= io_mon.approx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_trc_valid  <= 1'b0;
         r_trc_idx    <= '0;
         r_trc_exact  <= '0;
         r_trc_approx <= '0;
      end else if (w_start_ok) begin
         r_trc_valid  <= 1'b0;
         r_trc_idx    <= '0;
         r_trc_exact  <= '0;
         r_trc_approx <= '0;
      end else if (r_s1_valid && w_s1_viol && !r_trc_valid) begin
         r_trc_valid  <= 1'b1;
         r_trc_idx    <= r_s1_idx;
         r_trc_exact  <= r_s1_exact;
         r_trc_approx <= r_s1_approx;
      end
   end

   assign io_mon.trace_valid  = r_trc_valid;
   assign io_mon.trace_idx    = r_trc_idx;
   assign io_mon.trace_exact  = r_trc_exact;
   assign io_mon.trace_approx = r_trc_approx;
`endif

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign io_mon.in_ready  = (r_state == StRun);
   assign io_mon.busy      = (r_state == StRun) || (r_state == StDrain);
   assign io_mon.done      = (r_state == StDone);
   assign io_mon.fail      = (r_state == StDone) && (r_err_count != '0);
   assign io_mon.err_count = r_err_count;
   assign io_mon.max_hd    = r_max_hd;

endmodule
